usb_tx_line_encoder: RTL and testbench
======================================

// Module: usb_tx_line_encoder
// PURPOSE
// - Consumes the serial bit stream of the TX parallel-to-serial shifter and drives the USB full-speed D+/D- pair.
// - Applies NRZI encoding and bit stuffing (a 0 after STUFF_LEN consecutive 1s), then generates EOP (SE0 x2 bits, J x1 bit).
// - Back-pressures the shifter with stuff_stall so that no data bit is lost while a stuffed bit goes out.
// - Sits between the TX shift register (upstream) and the bus pad drivers (downstream).
// PARAMETERS
// - STUFF_LEN     6  count of consecutive 1s that triggers a stuffed 0
// - EOP_SE0_BITS  2  bit times of SE0 during EOP
// - CNT_W         3  width of the ones counter; must hold STUFF_LEN
// PORTS
// - clk          in   1  system clock; single clock domain
// - rst          in   1  synchronous, active-high reset
// - bit_strobe   in   1  1-cycle pulse per USB bit time; same strobe that shifts the TX shifter
// - tx_enable    in   1  packet transmission active; serial_in is valid on strobes
// - serial_in    in   1  current bit from the TX shifter output
// - eop_request  in   1  level; last data bit has been sent, begin EOP at next strobe
// - stuff_stall  out  1  combinational; high when this strobe inserts a stuffed bit
//                        upstream shift_enable = tx_enable & bit_strobe & ~stuff_stall
// - d_plus       out  1  registered D+
// - d_minus      out  1  registered D-
// - busy         out  1  high in DATA and every EOP state
// - eop_done     out  1  1-cycle pulse on the clock that leaves EOP_J
// BEHAVIOUR
// - Reset: state=IDLE, line=J (d_plus=1, d_minus=0), ones_cnt=0, busy=0, eop_done=0.
//   Reset mid-packet aborts immediately to the same values on the next clock; no EOP is sent.
// - Line state updates only on clocks where bit_strobe=1. Output latency is 1 clk (registered after the strobe).
// - FSM states: IDLE, DATA, EOP_SE0, EOP_J.
// - IDLE:
//   - Line held at J; ones_cnt=0.
//   - tx_enable & bit_strobe -> process serial_in as in DATA on this same strobe, go to DATA.
// - DATA, on each strobe:
//   - ones_cnt==STUFF_LEN: stuff_stall=1, toggle line (J<->K), ones_cnt<=0; serial_in is ignored.
//   - else serial_in=0: toggle line, ones_cnt<=0.
//   - else serial_in=1: hold line, ones_cnt<=ones_cnt+1 (saturates; cannot exceed STUFF_LEN).
//   - eop_request & strobe & ~stuff_stall: enter EOP_SE0, drive SE0 (0,0), se0_cnt<=1. This strobe carries no data bit.
//   - eop_request while a stuff is pending: send the stuffed bit first; EOP starts on the following strobe.
//   - tx_enable dropping without eop_request: treated as eop_request at the next strobe.
// - EOP_SE0: hold SE0; at each strobe se0_cnt++; when se0_cnt==EOP_SE0_BITS, drive J and go to EOP_J.
// - EOP_J: hold J for one bit time; at the next strobe go to IDLE and pulse eop_done.
// - stuff_stall is 0 outside DATA. eop_request/tx_enable are ignored in the EOP states.
// - Non-strobe clocks: all outputs and state are held; eop_done is a single pulse only.
// - Line state is never K outside DATA, and never SE0 outside EOP_SE0.
// STRUCTURE
// - Shared package usb_tx_pkg:
//   - state enum: IDLE, DATA, EOP_SE0, EOP_J
//   - line-state typedef and constants: LINE_J=2'b10, LINE_K=2'b01, LINE_SE0=2'b00 ({d_plus,d_minus})
// - Single module with no sub-module: FSM, ones counter, SE0 counter and line register.
//   The upstream shifter instance is composed at the top level.
// TESTING
// - Reset: hold rst for 3 clks mid-DATA -> next clk d_plus=1, d_minus=0, busy=0, stuff_stall=0.
// - SYNC byte, LSB-first 0,0,0,0,0,0,0,1 on strobes from J -> line K,J,K,J,K,J,K,K; no stall.
// - Eight 1s after a 0 -> line holds 6 strobes; stuff_stall=1 on the 7th strobe and the line toggles;
//   the 7th and 8th 1s hold the line; total 9 strobes consumed.
// - Exactly six 1s then eop_request -> stuffed toggle first, then SE0,SE0,J, then eop_done pulse on strobe 10.
// - Strobe every 8 clks -> outputs change only the clk after a strobe; eop_done is high for exactly 1 clk.
// - Drop tx_enable mid-byte with no eop_request -> EOP sequence SE0,SE0,J is generated, then IDLE.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types for the USB full-speed transmit path: FSM states and
// {d_plus,d_minus} line-state encodings.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } state_t;

  typedef logic [1:0] line_t;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  // NRZI transition between the two differential data states
  function automatic line_t line_toggle(input line_t line);
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_line_encoder.sv
// NRZI encoder with bit stuffing and EOP generation, driving the USB
// full-speed D+/D- pair from the TX shifter's serial output.
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_strobe,
  input  logic tx_enable,
  input  logic serial_in,
  input  logic eop_request,
  output logic stuff_stall,
  output logic d_plus,
  output logic d_minus,
  output logic busy,
  output logic eop_done
);

  localparam int unsigned SE0_W = $clog2(EOP_SE0_BITS + 1);

  state_t             state_q, state_d;
  line_t              line_q, line_d;
  logic [CNT_W-1:0]   ones_q, ones_d;
  logic [SE0_W-1:0]   se0_q, se0_d;
  logic               busy_q;
  logic               eop_done_q, eop_done_d;
  logic               stall_c;

  // Next-state, line and counter logic; everything advances only on strobes
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    ones_d     = ones_q;
    se0_d      = se0_q;
    eop_done_d = 1'b0;
    stall_c    = 1'b0;

    case (state_q)
      IDLE: begin
        line_d = LINE_J;
        ones_d = '0;
        se0_d  = '0;
        // First data bit is encoded on the same strobe that starts the packet
        if (bit_strobe && tx_enable) begin
          state_d = DATA;
          line_d  = serial_in ? LINE_J : LINE_K;
          ones_d  = serial_in ? CNT_W'(1) : '0;
        end
      end

      DATA: begin
        if (bit_strobe) begin
          if (ones_q == CNT_W'(STUFF_LEN)) begin
            // Stuffed zero outranks EOP so a pending stuff is never dropped
            stall_c = 1'b1;
            line_d  = line_toggle(line_q);
            ones_d  = '0;
          end else if (eop_request || !tx_enable) begin
            state_d = EOP_SE0;
            line_d  = LINE_SE0;
            ones_d  = '0;
            se0_d   = SE0_W'(1);
          end else if (!serial_in) begin
            line_d = line_toggle(line_q);
            ones_d = '0;
          end else begin
            ones_d = ones_q + CNT_W'(1);
          end
        end
      end

      EOP_SE0: begin
        if (bit_strobe) begin
          if (se0_q == SE0_W'(EOP_SE0_BITS)) begin
            state_d = EOP_J;
            line_d  = LINE_J;
            se0_d   = '0;
          end else begin
            se0_d = se0_q + SE0_W'(1);
          end
        end
      end

      EOP_J: begin
        if (bit_strobe) begin
          state_d    = IDLE;
          eop_done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        line_d  = LINE_J;
        ones_d  = '0;
        se0_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= LINE_J;
      ones_q     <= '0;
      se0_q      <= '0;
      busy_q     <= 1'b0;
      eop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      ones_q     <= ones_d;
      se0_q      <= se0_d;
      busy_q     <= (state_d != IDLE);
      eop_done_q <= eop_done_d;
    end
  end

  assign stuff_stall = stall_c;
  assign d_plus      = line_q[1];
  assign d_minus     = line_q[0];
  assign busy        = busy_q;
  assign eop_done    = eop_done_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Self-checking bench: random packets compared against a bit-level NRZI,
// stuffing and EOP reference built from the line-coding rules.
module tb_usb_tx_line_encoder;

  logic clk = 1'b0;
  logic rst;
  logic bit_strobe;
  logic tx_enable;
  logic serial_in;
  logic eop_request;
  logic stuff_stall;
  logic d_plus;
  logic d_minus;
  logic busy;
  logic eop_done;

  int checks   = 0;
  int failures = 0;

  bit         pkt[$];
  logic [1:0] obs_line[$];
  bit         obs_stall[$];

  usb_tx_line_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .bit_strobe  (bit_strobe),
    .tx_enable   (tx_enable),
    .serial_in   (serial_in),
    .eop_request (eop_request),
    .stuff_stall (stuff_stall),
    .d_plus      (d_plus),
    .d_minus     (d_minus),
    .busy        (busy),
    .eop_done    (eop_done)
  );

  always #5 clk = ~clk;

  // Sends pkt, then an EOP (via eop_request or by dropping tx_enable),
  // with gap_min..gap_max idle clocks between strobes.
  task automatic run_packet(input bit use_eop, input int gap_min, input int gap_max);
    logic [1:0] exp_line[$];
    bit         exp_stall[$];
    logic [1:0] cur;
    int         run;
    int         idx;
    int         last;
    int         gaps;

    cur = 2'b10;
    run = 0;
    foreach (pkt[i]) begin
      if (!pkt[i]) begin
        cur = (cur == 2'b10) ? 2'b01 : 2'b10;
        run = 0;
      end else begin
        run++;
      end
      exp_line.push_back(cur);
      exp_stall.push_back(1'b0);
      if (run == 6) begin
        cur = (cur == 2'b10) ? 2'b01 : 2'b10;
        run = 0;
        exp_line.push_back(cur);
        exp_stall.push_back(1'b1);
      end
    end
    exp_line.push_back(2'b00); exp_stall.push_back(1'b0);
    exp_line.push_back(2'b00); exp_stall.push_back(1'b0);
    exp_line.push_back(2'b10); exp_stall.push_back(1'b0);
    exp_line.push_back(2'b10); exp_stall.push_back(1'b0);

    obs_line.delete();
    obs_stall.delete();
    idx  = 0;
    last = exp_line.size() - 1;

    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      bit_strobe = 1'b1;
      if (idx < pkt.size()) begin
        tx_enable   = 1'b1;
        eop_request = 1'b0;
        serial_in   = pkt[idx];
      end else if (k == last) begin
        tx_enable   = 1'b0;
        eop_request = 1'b0;
        serial_in   = 1'($urandom);
      end else begin
        tx_enable   = use_eop;
        eop_request = use_eop;
        serial_in   = 1'($urandom);
      end
      #1;
      checks++;
      if (stuff_stall !== exp_stall[k]) begin
        failures++;
        $display("FAIL stuff_stall strobe=%0d got=%b exp=%b", k, stuff_stall, exp_stall[k]);
      end
      obs_stall.push_back(stuff_stall);

      @(posedge clk);
      #1;
      obs_line.push_back({d_plus, d_minus});
      checks++;
      if ({d_plus, d_minus} !== exp_line[k]) begin
        failures++;
        $display("FAIL line strobe=%0d got=%b exp=%b", k, {d_plus, d_minus}, exp_line[k]);
      end
      checks++;
      if (busy !== (k != last)) begin
        failures++;
        $display("FAIL busy strobe=%0d got=%b exp=%b", k, busy, (k != last));
      end
      checks++;
      if (eop_done !== (k == last)) begin
        failures++;
        $display("FAIL eop_done strobe=%0d got=%b exp=%b", k, eop_done, (k == last));
      end
      if (!exp_stall[k] && idx < pkt.size()) idx++;

      gaps = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        bit_strobe  = 1'b0;
        serial_in   = 1'($urandom);
        eop_request = 1'($urandom);
        tx_enable   = 1'($urandom);
        @(posedge clk);
        #1;
        checks++;
        if ({d_plus, d_minus} !== exp_line[k] || eop_done !== 1'b0) begin
          failures++;
          $display("FAIL gap_hold strobe=%0d gap=%0d got=%b/%b exp=%b/0",
                   k, g, {d_plus, d_minus}, eop_done, exp_line[k]);
        end
      end
    end

    @(negedge clk);
    bit_strobe  = 1'b0;
    tx_enable   = 1'b0;
    eop_request = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (eop_done !== 1'b0 || busy !== 1'b0 || {d_plus, d_minus} !== 2'b10) begin
      failures++;
      $display("FAIL post_packet got done=%b busy=%b line=%b exp done=0 busy=0 line=10",
               eop_done, busy, {d_plus, d_minus});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_strobe = 1'b0; tx_enable = 1'b0; serial_in = 1'b0; eop_request = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({d_plus, d_minus, busy, eop_done, stuff_stall} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_init got=%b exp=10000", {d_plus, d_minus, busy, eop_done, stuff_stall});
    end
    @(negedge clk);
    rst = 1'b0; bit_strobe = 1'b1; tx_enable = 1'b1; serial_in = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({d_plus, d_minus, busy} !== 3'b011) begin
      failures++;
      $display("FAIL reset_predata got=%b exp=011", {d_plus, d_minus, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({d_plus, d_minus, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_abort got=%b exp=100", {d_plus, d_minus, busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bit_strobe = 1'b0; tx_enable = 1'b0;
    #1;
    checks++;
    if ({d_plus, d_minus, busy, stuff_stall} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_release got=%b exp=1000", {d_plus, d_minus, busy, stuff_stall});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bit_strobe = 1'(i % 2);
      @(posedge clk);
      #1;
      checks++;
      if ({d_plus, d_minus, busy, eop_done} !== 4'b1000) begin
        failures++;
        $display("FAIL reset_no_eop i=%0d got=%b exp=1000", i, {d_plus, d_minus, busy, eop_done});
      end
    end
    @(negedge clk);
    bit_strobe = 1'b0;
  endtask

  task automatic test_sync();
    logic [1:0] sync_exp[8];
    int         stalls;
    sync_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
    pkt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_packet(1'b1, 0, 2);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_line[i] !== sync_exp[i]) begin
        failures++;
        $display("FAIL sync_line i=%0d got=%b exp=%b", i, obs_line[i], sync_exp[i]);
      end
      if (obs_stall[i]) stalls++;
    end
    checks++;
    if (stalls != 0) begin
      failures++;
      $display("FAIL sync_stall got=%0d exp=0", stalls);
    end
  endtask

  task automatic test_stuff8();
    pkt = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_packet(1'b1, 0, 1);
    checks++;
    if (obs_line.size() != 14) begin
      failures++;
      $display("FAIL stuff8_len got=%0d exp=14", obs_line.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs_stall[i] !== (i == 7)) begin
        failures++;
        $display("FAIL stuff8_stall i=%0d got=%b exp=%b", i, obs_stall[i], (i == 7));
      end
      checks++;
      if (obs_line[i] !== ((i < 7) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL stuff8_line i=%0d got=%b exp=%b", i, obs_line[i], ((i < 7) ? 2'b01 : 2'b10));
      end
    end
  endtask

  task automatic test_six_ones_eop();
    logic [1:0] exp6[11];
    exp6 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10};
    pkt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_packet(1'b1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (obs_line[i] !== exp6[i] || obs_stall[i] !== (i == 6)) begin
        failures++;
        $display("FAIL six_ones i=%0d got=%b/%b exp=%b/%b",
                 i, obs_line[i], obs_stall[i], exp6[i], (i == 6));
      end
    end
  endtask

  task automatic test_slow_strobe();
    pkt.delete();
    for (int i = 0; i < 12; i++) pkt.push_back($urandom_range(3, 0) != 0);
    run_packet(1'b1, 7, 7);
  endtask

  task automatic test_tx_drop();
    int n;
    pkt = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    run_packet(1'b0, 0, 2);
    n = obs_line.size();
    checks++;
    if (obs_line[n-4] !== 2'b00 || obs_line[n-3] !== 2'b00 || obs_line[n-2] !== 2'b10) begin
      failures++;
      $display("FAIL tx_drop_eop got=%b,%b,%b exp=00,00,10", obs_line[n-4], obs_line[n-3], obs_line[n-2]);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int p = 0; p < 20; p++) begin
      pkt.delete();
      len = $urandom_range(24, 1);
      for (int i = 0; i < len; i++) pkt.push_back($urandom_range(3, 0) != 0);
      run_packet(1'($urandom), 0, $urandom_range(3, 0));
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stuff8();
    test_six_ones_eop();
    test_slow_strobe();
    test_tx_drop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
